approx_mult_acc_ctrl: RTL
=========================

Name: approx_mult_acc_ctrl

Overview:
- Closed-loop accuracy controller and pipeline wrapper placed directly around the controllable 8x8 approximate multiplier.
- Upstream role: registers operands and drives `mask_x`.
- Downstream role: consumes the multiplier's 16-bit product, registers it for the next stage, and measures the approximation error against an exact reference product.
- Error is accumulated over fixed windows; a mode FSM switches the multiplier between approximate and accurate operation.

Parameters:
- WIN_LOG2, 4, log2 of samples per error window (default window = 16 products).
- ERR_HI, 256, window error sum strictly above this value forces ACCURATE.
- HOLD_WIN, 2, number of complete windows spent in ACCURATE before returning to APPROX (must be ≥1).
- ACC_W, 24, error accumulator width; accumulator saturates at 2^ACC_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- mode_sel  in  2  00 auto, 01 force approx, 10 force accurate, 11 treated as 00.
- mul_a  out  8  to multiplier a (stage-1 register).
- mul_b  out  8  to multiplier b (stage-1 register).
- mul_mask_x  out  1  to multiplier mask_x; 1 = accurate carries, 0 = approximate.
- mul_product  in  16  combinational product returned by the multiplier for mul_a/mul_b/mul_mask_x.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts.
- out_product  out  16  registered approximate product.
- out_err  out  16  |a*b - product| for out_product.
- out_mask  out  1  mask_x used for out_product.
- mode_acc  out  1  current FSM mode (1 = ACCURATE).

Behaviour:
- Reset values: all outputs 0; in_ready=1 after reset; FSM in APPROX; accumulator, sample counter and hold counter 0.
- Stage 1 (s1): holds {mul_a, mul_b, mul_mask_x, s1_valid}.
- Stage 2 (s2): holds {out_product, out_err, out_mask, out_valid}.
- Advance rules:
  - s2_adv = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_adv.
  - Operands are accepted when in_valid & in_ready.
  - On accept, s1 loads in_a, in_b and mask = mode_acc after any update in the same cycle.
  - On s1_valid & s2_adv, s2 loads mul_product, abs(in-stage exact s1 product - mul_product) and s1 mask.
  - If s1 is not refilled on that edge, s1_valid clears.
- Latency and throughput: 2 cycles from accept to out_valid; throughput 1 product per cycle with out_ready held high.
- Stall: while out_valid & !out_ready, s1 and s2 hold and all outputs stay stable.
- Exact reference: full 16-bit unsigned a*b computed from the s1 registers. The error is a 16-bit absolute difference; the approximate product may be above or below the exact value.
- Window accounting (auto mode only):
  - Counted on each s1→s2 transfer whose mask = 0.
  - Accumulator adds err, saturating at 2^ACC_W-1.
  - Sample counter increments; when it reaches 2^WIN_LOG2, the window closes and accumulator and counter clear.
  - Transfers with mask = 1 count windows for HOLD only; they do not accumulate.
- FSM:
  - APPROX→ACCURATE when a window closes with sum > ERR_HI (sum == ERR_HI stays APPROX); hold counter clears.
  - ACCURATE: hold counter increments per closed window; at HOLD_WIN → APPROX, with accumulator/counter cleared.
  - Forced modes: mode_sel=01 forces mode_acc=0 and mode_sel=10 forces mode_acc=1 from the next cycle. While forced, the accumulator, sample counter and hold counter are held at 0.
  - A return to 00 resumes auto mode from the forced state with fresh windows.
- Mode-change timing: a mode change only affects operands accepted after the change. Operands already in s1/s2 keep their mask.
- Reset mid-operation: clears both stages immediately; in-flight data is discarded and out_valid deasserts asynchronously.

Optional Feature:
- Macro ERR_STATS_EN.
- Defined:
  - Adds output err_max (16), the largest out_err seen since reset.
  - Adds output win_count (16), closed windows since reset, wrapping at 2^16.
  - Adds output switch_count (8), APPROX→ACCURATE transitions, saturating at 255.
  - All three reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then a=8'd12, b=8'd10 with mode_sel=10, out_ready=1 → out_valid exactly 2 cycles after accept; mul_mask_x=1 for that operand; out_mask=1.
- Back-to-back 20 operands, out_ready=1 → one out_valid per cycle, order preserved. Then out_ready=0 for 5 cycles → in_ready low once s1 is full, and out_product/out_err stable throughout.
- Auto mode, 16 products, bench model returns mul_product = exact+17 → window sum 272 > 256 → mode_acc rises after the 16th transfer; the 17th accepted operand has mask 1.
- Same scenario with error 16 per sample → sum 256 == ERR_HI → stays APPROX.
- In ACCURATE with HOLD_WIN=2 → after 32 further transfers, mode_acc returns to 0; accumulator reads 0 for the next window.
- Assert rst_n low mid-stream with out_valid=1 → out_valid=0 and mode_acc=0 immediately. With ERR_STATS_EN, err_max=0 after reset and equals 17 after the error scenario.

Source files
------------

// File: rtl/approx_mult_acc_ctrl.sv
// Closed-loop accuracy controller and 2-stage wrapper for an 8x8 approximate multiplier.
// Define ERR_STATS_EN to add the err_max / win_count / switch_count statistics outputs.
module approx_mult_acc_ctrl #(
  parameter int WIN_LOG2 = 4,
  parameter int ERR_HI   = 256,
  parameter int HOLD_WIN = 2,
  parameter int ACC_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [1:0]  mode_sel,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_mask_x,
  input  logic [15:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic [15:0] out_err,
  output logic        out_mask,
`ifdef ERR_STATS_EN
  output logic [15:0] err_max,
  output logic [15:0] win_count,
  output logic [7:0]  switch_count,
`endif
  output logic        mode_acc
);

  localparam int HW = (HOLD_WIN < 2) ? 1 : $clog2(HOLD_WIN);

  typedef enum logic {
    APPROX   = 1'b0,
    ACCURATE = 1'b1
  } mode_e;

  mode_e st_q, st_d;

  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        mask_q, mask_d;
  logic        s1_vld_q, s1_vld_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] err_q, err_d;
  logic        omask_q, omask_d;
  logic        s2_vld_q, s2_vld_d;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic             s2_adv;
  logic             accept;
  logic             xfer;
  logic             auto_m;
  logic             win_close;
  logic [15:0]      exact;
  logic [15:0]      err;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;
  logic [ACC_W-1:0] acc_win;

  always_comb begin
    s2_adv   = !s2_vld_q || out_ready;
    in_ready = !s1_vld_q || s2_adv;
    accept   = in_valid && in_ready;
    xfer     = s1_vld_q && s2_adv;
    // 00 and 11 both select closed-loop operation
    auto_m   = (mode_sel[0] == mode_sel[1]);

    exact = {8'h00, a_q} * {8'h00, b_q};
    err   = (exact > mul_product) ? (exact - mul_product)
                                  : (mul_product - exact);

    acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, err};
    acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    acc_win = mask_q ? acc_q : acc_sat;

    st_d      = st_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    win_close = 1'b0;

    if (!auto_m) begin
      st_d   = mode_sel[1] ? ACCURATE : APPROX;
      acc_d  = '0;
      cnt_d  = '0;
      hold_d = '0;
    end else if (xfer) begin
      if (cnt_q == {WIN_LOG2{1'b1}}) begin
        win_close = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        unique case (1'b1)
          (st_q == APPROX): begin
            if (acc_win > ACC_W'(ERR_HI)) begin
              st_d   = ACCURATE;
              hold_d = '0;
            end
          end
          (st_q == ACCURATE): begin
            if (hold_q == HW'(HOLD_WIN - 1)) begin
              st_d   = APPROX;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        acc_d = acc_win;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    mask_d   = mask_q;
    s1_vld_d = s1_vld_q;
    if (accept) begin
      a_d      = in_a;
      b_d      = in_b;
      // new operands see the mode decided on this same edge
      mask_d   = (st_d == ACCURATE);
      s1_vld_d = 1'b1;
    end else if (xfer) begin
      s1_vld_d = 1'b0;
    end

    prod_d   = prod_q;
    err_d    = err_q;
    omask_d  = omask_q;
    s2_vld_d = s2_vld_q;
    if (xfer) begin
      prod_d   = mul_product;
      err_d    = err;
      omask_d  = mask_q;
      s2_vld_d = 1'b1;
    end else if (s2_adv) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= APPROX;
      a_q      <= '0;
      b_q      <= '0;
      mask_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      prod_q   <= '0;
      err_q    <= '0;
      omask_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      st_q     <= st_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mask_q   <= mask_d;
      s1_vld_q <= s1_vld_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      omask_q  <= omask_d;
      s2_vld_q <= s2_vld_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_mask_x  = mask_q;
  assign out_valid   = s2_vld_q;
  assign out_product = prod_q;
  assign out_err     = err_q;
  assign out_mask    = omask_q;
  assign mode_acc    = (st_q == ACCURATE);

`ifdef ERR_STATS_EN
  logic [15:0] emax_q, emax_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  swc_q, swc_d;

  always_comb begin
    emax_d = emax_q;
    wcnt_d = wcnt_q;
    swc_d  = swc_q;
    if (xfer && (err > emax_q)) emax_d = err;
    if (win_close) wcnt_d = wcnt_q + 16'd1;
    if ((st_q == APPROX) && (st_d == ACCURATE) && (swc_q != 8'hff))
      swc_d = swc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emax_q <= '0;
      wcnt_q <= '0;
      swc_q  <= '0;
    end else begin
      emax_q <= emax_d;
      wcnt_q <= wcnt_d;
      swc_q  <= swc_d;
    end
  end

  assign err_max      = emax_q;
  assign win_count    = wcnt_q;
  assign switch_count = swc_q;
`endif

endmodule
